// File: rtl/mem_access_sequencer.sv
// Splits one RV32 load/store into little-endian byte accesses on a byte-wide
// array port, one byte per cycle, and returns the assembled/extended result.
module mem_access_sequencer #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [7:0]            mem_write_data,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [7:0]            mem_read_data
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_STORE      = 3'd1;
    localparam logic [2:0] S_LOAD_ISSUE = 3'd2;
    localparam logic [2:0] S_LOAD_DRAIN = 3'd3;
    localparam logic [2:0] S_RESP       = 3'd4;

    // Handshake: a request transfers on the rising edge where req_valid and
    // req_ready are both high; resp_valid is a single-cycle pulse, never stalled.

    logic [2:0]  state;
    logic [1:0]  last_idx;     // N-1 of the accepted request
    logic [1:0]  byte_idx;     // byte currently driven on the array port
    logic        lat_signed;
    logic [31:0] lat_wdata;
    logic        rd_pending;   // a read issued last cycle returns data this cycle
    logic [1:0]  rd_lane;
    logic [31:0] rd_buf;

    logic [1:0]  req_last;
    logic        funct_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic        accept;
    logic [1:0]  byte_nxt;
    logic [31:0] merged_buf;
    logic [31:0] load_result;

    always_comb begin
        req_last = 2'd0;
        funct_ok = 1'b0;
        case (req_funct3)
            3'd0: begin req_last = 2'd0; funct_ok = 1'b1;       end
            3'd1: begin req_last = 2'd1; funct_ok = 1'b1;       end
            3'd2: begin req_last = 2'd3; funct_ok = 1'b1;       end
            3'd4: begin req_last = 2'd0; funct_ok = !req_write; end
            3'd5: begin req_last = 2'd1; funct_ok = !req_write; end
            default: begin req_last = 2'd0; funct_ok = 1'b0;    end
        endcase
    end

    assign misaligned   = ((req_last == 2'd1) && req_addr[0]) ||
                          ((req_last == 2'd3) && (req_addr[1:0] != 2'b00));
    assign out_of_range = |req_addr[31:ADDR_WIDTH];
    assign req_err      = !funct_ok || misaligned || out_of_range;
    assign accept       = req_valid && req_ready;
    assign byte_nxt     = byte_idx + 2'd1;

    // Returning read byte merged into its lane, so the final byte can be
    // folded into the response in the same cycle it arrives.
    always_comb begin
        merged_buf = rd_buf;
        if (rd_pending) begin
            merged_buf[{rd_lane, 3'b000} +: 8] = mem_read_data;
        end
    end

    always_comb begin
        load_result = merged_buf;
        case (last_idx)
            2'd0: load_result = lat_signed ? {{24{merged_buf[7]}}, merged_buf[7:0]}
                                           : {24'h0, merged_buf[7:0]};
            2'd1: load_result = lat_signed ? {{16{merged_buf[15]}}, merged_buf[15:0]}
                                           : {16'h0, merged_buf[15:0]};
            default: load_result = merged_buf;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            req_ready         <= 1'b1;
            resp_valid        <= 1'b0;
            resp_err          <= 1'b0;
            resp_rdata        <= 32'h0;
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= 8'h0;
            mem_read_enable   <= 1'b0;
            mem_read_address  <= '0;
            last_idx          <= 2'd0;
            byte_idx          <= 2'd0;
            lat_signed        <= 1'b0;
            lat_wdata         <= 32'h0;
            rd_pending        <= 1'b0;
            rd_lane           <= 2'd0;
            rd_buf            <= 32'h0;
        end else begin
            rd_pending <= mem_read_enable;
            rd_lane    <= byte_idx;
            if (rd_pending) begin
                rd_buf <= merged_buf;
            end

            case (state)
                S_IDLE: begin
                    resp_valid <= 1'b0;
                    if (accept) begin
                        req_ready  <= 1'b0;
                        last_idx   <= req_last;
                        byte_idx   <= 2'd0;
                        lat_signed <= !req_funct3[2];
                        lat_wdata  <= req_wdata;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= S_RESP;
                        end else if (req_write) begin
                            mem_write_enable  <= 1'b1;
                            mem_write_address <= req_addr[ADDR_WIDTH-1:0];
                            mem_write_data    <= req_wdata[7:0];
                            state             <= S_STORE;
                        end else begin
                            mem_read_enable  <= 1'b1;
                            mem_read_address <= req_addr[ADDR_WIDTH-1:0];
                            rd_buf           <= 32'h0;
                            state            <= S_LOAD_ISSUE;
                        end
                    end
                end

                S_STORE: begin
                    if (byte_idx == last_idx) begin
                        mem_write_enable <= 1'b0;
                        resp_valid       <= 1'b1;
                        resp_err         <= 1'b0;
                        resp_rdata       <= 32'h0;
                        state            <= S_RESP;
                    end else begin
                        byte_idx          <= byte_nxt;
                        mem_write_address <= mem_write_address + 1'b1;
                        mem_write_data    <= lat_wdata[{byte_nxt, 3'b000} +: 8];
                    end
                end

                S_LOAD_ISSUE: begin
                    if (byte_idx == last_idx) begin
                        mem_read_enable <= 1'b0;
                        state           <= S_LOAD_DRAIN;
                    end else begin
                        byte_idx         <= byte_nxt;
                        mem_read_address <= mem_read_address + 1'b1;
                    end
                end

                S_LOAD_DRAIN: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_result;
                    state      <= S_RESP;
                end

                S_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end

                default: begin
                    mem_write_enable <= 1'b0;
                    mem_read_enable  <= 1'b0;
                    resp_valid       <= 1'b0;
                    req_ready        <= 1'b1;
                    state            <= S_IDLE;
                end
            endcase
        end
    end

endmodule
